mrsw_raddr_ram: RTL and testbench

- Parametrised multi-read, single-write synchronous RAM; successor to the single-port registered-read-address RAM.
- Adds a configurable number of independent read ports, per-byte write strobes and a selectable read-register mode.
- Adds per-port read-valid flags and defined behaviour for out-of-range addresses.
- Used as a user-design memory primitive inside emulated DUTs; the memory array is a plain register array, so the emulation RAM-scan flow can extract it.

---
 rtl/mrsw_raddr_ram.sv | 93 +++++++++
 tb/tb_mrsw_raddr_ram.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mrsw_raddr_ram.sv
// mrsw_raddr_ram: single-write, multi-read synchronous RAM with byte strobes.
// Each read port registers either its address (RDMODE=0) or its data (RDMODE=1).
module mrsw_raddr_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int NRD        = 2,
  parameter int RDMODE     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wen,
  input  logic [ADDR_WIDTH-1:0]      waddr,
  input  logic [DATA_WIDTH/8-1:0]    wstrb,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [NRD-1:0]             ren,
  input  logic [NRD*ADDR_WIDTH-1:0]  raddr,
  output logic [NRD*DATA_WIDTH-1:0]  rdata,
  output logic [NRD-1:0]             rvalid
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_LIM;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rd_word(input logic [ADDR_WIDTH-1:0] a);
    return addr_ok(a) ? mem[a] : '0;
  endfunction

  // The array has no reset so it stays a plain register array; rst only gates writes.
  always_ff @(posedge clk) begin
    if (wen && !rst && addr_ok(waddr)) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rvalid <= '0;
    else     rvalid <= ren;
  end

  generate
    if (RDMODE == 0) begin : g_areg
      logic [ADDR_WIDTH-1:0] raddr_q [NRD];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int p = 0; p < NRD; p++) raddr_q[p] <= '0;
        end else begin
          for (int p = 0; p < NRD; p++) begin
            if (ren[p]) raddr_q[p] <= raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
          end
        end
      end

      // Held address re-reads the array every cycle, so later writes show through.
      always_comb begin
        rdata = '0;
        for (int p = 0; p < NRD; p++) begin
          rdata[p*DATA_WIDTH +: DATA_WIDTH] = rd_word(raddr_q[p]);
        end
      end
    end else begin : g_dreg
      logic [DATA_WIDTH-1:0] rdata_q [NRD];

      // Sampling mem on the write edge returns the pre-write word (read-first).
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int p = 0; p < NRD; p++) rdata_q[p] <= '0;
        end else begin
          for (int p = 0; p < NRD; p++) begin
            if (ren[p]) rdata_q[p] <= rd_word(raddr[p*ADDR_WIDTH +: ADDR_WIDTH]);
          end
        end
      end

      always_comb begin
        rdata = '0;
        for (int p = 0; p < NRD; p++) begin
          rdata[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q[p];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_mrsw_raddr_ram.sv
// Testbench for mrsw_raddr_ram: four instances (both read modes, DEPTH 4 and 3)
// share one stimulus stream; expected read data is queued and checked on rvalid.
module tb_mrsw_raddr_ram;

  localparam int DW  = 32;
  localparam int AW  = 2;
  localparam int NRD = 2;
  localparam int NI  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt = 1'b0;
  logic gclk;
  logic wen = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [3:0] wstrb = '0;
  logic [DW-1:0] wdata = '0;
  logic [NRD-1:0] ren = '0;
  logic [NRD*AW-1:0] raddr = '0;
  logic [NRD*DW-1:0] rd [NI];
  logic [NRD-1:0] rv [NI];

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q [NI][NRD][$];
  logic [DW-1:0] mdl [NI][4];

  always #5 clk = ~clk;
  assign gclk = clk & ~halt;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mrsw_raddr_ram #(
      .DATA_WIDTH(DW), .DEPTH(g < 2 ? 4 : 3), .ADDR_WIDTH(AW),
      .NRD(NRD), .RDMODE((g == 1 || g == 2) ? 1 : 0)
    ) u_dut (
      .clk(gclk), .rst(rst), .wen(wen), .waddr(waddr), .wstrb(wstrb),
      .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rd[g]), .rvalid(rv[g])
    );
  end

  function automatic int dep(input int i);
    return (i < 2) ? 4 : 3;
  endfunction

  function automatic int mode(input int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [3:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // One cycle of stimulus, driven while clk is low; model and queues advance only on a real edge.
  task automatic step(input logic w, input logic [AW-1:0] wa, input logic [3:0] ws,
                      input logic [DW-1:0] wd, input logic [1:0] re,
                      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1, input logic h);
    int a;
    logic [DW-1:0] v;
    wen = w; waddr = wa; wstrb = ws; wdata = wd; ren = re; raddr = {ra1, ra0}; halt = h;
    if (!h && !rst) begin
      for (int i = 0; i < NI; i++) begin
        for (int p = 0; p < NRD; p++) begin
          if (re[p]) begin
            a = (p == 0) ? int'(ra0) : int'(ra1);
            if (a >= dep(i)) v = '0;
            else if (mode(i) == 0 && w && int'(wa) == a) v = merge(mdl[i][a], wd, ws);
            else v = mdl[i][a];
            exp_q[i][p].push_back(v);
          end
        end
        if (w && int'(wa) < dep(i)) mdl[i][wa] = merge(mdl[i][wa], wd, ws);
      end
    end
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!halt) begin
      for (int i = 0; i < NI; i++) begin
        for (int p = 0; p < NRD; p++) begin
          if (rv[i][p]) begin
            if (exp_q[i][p].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL spurious_rvalid_u%0d_p%0d: got rvalid 1 want 0", i, p);
            end else begin
              chk($sformatf("rdata_u%0d_p%0d", i, p), 64'(rd[i][p*DW +: DW]),
                  64'(exp_q[i][p].pop_front()));
            end
          end
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) chk($sformatf("reset_rvalid_u%0d", i), 64'(rv[i]), 64'd0);
    chk("reset_rdata_u1", rd[1], 64'd0);
    chk("reset_rdata_u2", rd[2], 64'd0);

    step(1'b1, 2'd1, 4'hF, 32'hDEADBEEF, 2'b00, 2'd0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 4'h0, 32'h0, 2'b11, 2'd1, 2'd1, 1'b0);
    chk("rvalid_pulse_u1", 64'(rv[1]), 64'd3);
    chk("both_ports_u1", rd[1], {32'hDEADBEEF, 32'hDEADBEEF});
    step(1'b0, 2'd0, 4'h0, 32'h0, 2'b00, 2'd0, 2'd0, 1'b0);
    chk("rvalid_drop_u1", 64'(rv[1]), 64'd0);

    step(1'b1, 2'd2, 4'hF, 32'h11223344, 2'b00, 2'd0, 2'd0, 1'b0);
    step(1'b1, 2'd2, 4'b0101, 32'hAABBCCDD, 2'b00, 2'd0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 4'h0, 32'h0, 2'b01, 2'd2, 2'd0, 1'b0);
    chk("byte_strobe_u0", 64'(rd[0][31:0]), 64'h11BB33DD);

    step(1'b1, 2'd3, 4'hF, 32'h5, 2'b00, 2'd0, 2'd0, 1'b0);
    step(1'b1, 2'd3, 4'hF, 32'h9, 2'b11, 2'd3, 2'd3, 1'b0);
    chk("collision_mode0", 64'(rd[0][31:0]), 64'h9);
    chk("collision_mode1", 64'(rd[1][63:32]), 64'h5);
    chk("collision_oor_u2", rd[2], 64'd0);
    step(1'b0, 2'd0, 4'h0, 32'h0, 2'b01, 2'd3, 2'd0, 1'b0);
    chk("reread_mode1", 64'(rd[1][31:0]), 64'h9);

    step(1'b1, 2'd0, 4'hF, 32'h77, 2'b00, 2'd0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 4'h0, 32'h0, 2'b11, 2'd0, 2'd0, 1'b0);
    step(1'b1, 2'd0, 4'hF, 32'h88, 2'b00, 2'd2, 2'd2, 1'b0);
    chk("hold_writethru_mode0", 64'(rd[0][31:0]), 64'h88);
    chk("hold_mode1", 64'(rd[1][31:0]), 64'h77);

    step(1'b1, 2'd3, 4'hF, 32'hFFFF, 2'b00, 2'd0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 4'h0, 32'h0, 2'b10, 2'd0, 2'd3, 1'b0);
    chk("oor_rdata_u3", 64'(rd[3][63:32]), 64'd0);
    chk("oor_rvalid_u3", 64'(rv[3]), 64'd2);
    step(1'b0, 2'd0, 4'h0, 32'h0, 2'b11, 2'd0, 2'd1, 1'b0);
    step(1'b0, 2'd0, 4'h0, 32'h0, 2'b01, 2'd2, 2'd0, 1'b0);
    chk("oor_intact_u2", 64'(rd[2][31:0]), 64'h11BB33DD);

    for (int a = 0; a < 4; a++) step(1'b1, AW'(a), 4'hF, $urandom, 2'b00, 2'd0, 2'd0, 1'b0);

    for (int c = 0; c < 500; c++) begin
      if (c == 250) begin
        step(1'b0, 2'd0, 4'h0, 32'h0, 2'b11, 2'd2, 2'd1, 1'b0);
        rst = 1'b1; ren = '0; wen = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("async_rst_rvalid_u%0d", i), 64'(rv[i]), 64'd0);
          chk($sformatf("async_rst_rdata_u%0d", i), rd[i],
              (mode(i) == 1) ? 64'd0 : {mdl[i][0], mdl[i][0]});
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
      end
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           $urandom, 2'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
           AW'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
    end
    step(1'b0, 2'd0, 4'h0, 32'h0, 2'b00, 2'd0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 4'h0, 32'h0, 2'b00, 2'd0, 2'd0, 1'b0);

    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("missing_rvalid_u%0d_p%0d", i, p), 64'(exp_q[i][p].size()), 64'd0);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
